// File: rtl/bin2bcd_pkg.sv
// Shared constants, register map and FSM encoding for the bin2bcd peripheral.
// Optional feature macro: PERIPHERAL_BIN2BCD_SIGNED_EN (two's complement DATA).
package bin2bcd_pkg;

   localparam int NUM_BITS   = 16;
   localparam int NUM_DIGITS = 5;
   localparam int BCD_W      = NUM_DIGITS * 4;
   localparam int CNT_W      = $clog2(NUM_BITS);
   localparam int ADDR_W     = 5;
   localparam int DOUT_W     = 32;

   localparam logic [ADDR_W-1:0] ADDR_DATA   = 5'h04;
   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'h08;
   localparam logic [ADDR_W-1:0] ADDR_RESULT = 5'h10;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h14;

   localparam logic [NUM_BITS-1:0] ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   // Two's complement magnitude; 0x8000 maps to 32768 unsigned.
   function automatic logic [NUM_BITS-1:0] mag(
      input logic [NUM_BITS-1:0] v
   );
      return v[NUM_BITS-1] ? (~v + ONE) : v;
   endfunction

endpackage

// File: rtl/peripheral_bin2bcd_if.sv
// CPU bus bundle shared by the stopwatch peripherals.
// Master drives cs/rd/wr/addr/d_in; slave returns d_out.
interface peripheral_bin2bcd_if;
   import bin2bcd_pkg::*;

   logic [NUM_BITS-1:0] d_in;
   logic                cs;
   logic [ADDR_W-1:0]   addr;
   logic                rd;
   logic                wr;
   logic [DOUT_W-1:0]   d_out;

   modport master (
      output d_in, cs, addr, rd, wr,
      input  d_out
   );

   modport slave (
      input  d_in, cs, addr, rd, wr,
      output d_out
   );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: digits of 5 or more get +3 (4-bit wrap).
// A valid BCD input always yields a result that shifts into a valid digit.
module bcd_add3 (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/peripheral_bin2bcd.sv
// Memory-mapped 16-bit binary to 5-digit BCD converter (shift-add-3).
// Optional feature macro: PERIPHERAL_BIN2BCD_SIGNED_EN.
module peripheral_bin2bcd
   import bin2bcd_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   peripheral_bin2bcd_if.slave bus
);

   logic [NUM_BITS-1:0] r_data;
   logic [NUM_BITS-1:0] r_bin;
   logic [BCD_W-1:0]    r_bcd;
   logic [BCD_W-1:0]    r_result;
   logic                r_sign;
   logic                r_res_sign;
   logic                r_done;
   logic                r_busy;
   logic [CNT_W-1:0]    r_cnt;
   state_t              r_state;
   logic [DOUT_W-1:0]   r_dout;

   logic                w_wr;
   logic                w_rd;
   logic                w_start;
   logic [BCD_W-1:0]    w_corr;
   logic [BCD_W-1:0]    w_next_bcd;
   logic [NUM_BITS-1:0] w_load_bin;
   logic                w_load_sign;
   logic [DOUT_W-1:0]   w_rdata;

   assign w_wr    = bus.cs & bus.wr;
   assign w_rd    = bus.cs & bus.rd;
   assign w_start = w_wr & (bus.addr == ADDR_CTRL) & bus.d_in[0];

`ifdef PERIPHERAL_BIN2BCD_SIGNED_EN
   assign w_load_sign = r_data[NUM_BITS-1];
   assign w_load_bin  = mag(r_data);
`else
   assign w_load_sign = 1'b0;
   assign w_load_bin  = r_data;
`endif

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_add3 u_add3 (
         .i_digit (r_bcd[g*4 +: 4]),
         .o_digit (w_corr[g*4 +: 4])
      );
   end

   // Corrected digits shift left, pulling in the next binary MSB.
   assign w_next_bcd = {w_corr[BCD_W-2:0], r_bin[NUM_BITS-1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
      end else if (w_wr && (bus.addr == ADDR_DATA)) begin
         r_data <= bus.d_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_result   <= '0;
         r_res_sign <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_bin   <= w_load_bin;
                  r_sign  <= w_load_sign;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd <= w_next_bcd;
               r_bin <= {r_bin[NUM_BITS-2:0], 1'b0};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(NUM_BITS - 1)) begin
                  r_result   <= w_next_bcd;
                  r_res_sign <= r_sign;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rdata = '0;
      unique case (1'b1)
         (bus.addr == ADDR_RESULT):
            w_rdata = {11'b0, r_res_sign, r_result};
         (bus.addr == ADDR_STATUS):
            w_rdata = {30'b0, r_busy, r_done};
         default: ;
      endcase
   end

   // Sampled before any same-cycle write lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout <= '0;
      end else if (w_rd) begin
         r_dout <= w_rdata;
      end
   end

   assign bus.d_out = r_dout;

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// Scoreboard bench for peripheral_bin2bcd: driver + reference model,
// monitor pops expected read data whenever a read completes.
module tb_peripheral_bin2bcd;
   import bin2bcd_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   peripheral_bin2bcd_if bus ();

   peripheral_bin2bcd dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] exp;
   } rd_t;

   rd_t sb_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;

   logic [15:0] m_data;
   logic [15:0] m_op;
   logic [31:0] m_result;
   bit          m_busy;
   bit          m_done;
   int          m_left;

   function automatic logic [31:0] ref_conv(input logic [15:0] v);
      int          m;
      bit          s;
      logic [31:0] r;
      m = int'(v);
      s = 1'b0;
`ifdef PERIPHERAL_BIN2BCD_SIGNED_EN
      if (v[15]) begin
         m = 65536 - int'(v);
         s = 1'b1;
      end
`endif
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      r[20] = s;
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      if (a == 5'h10) return m_result;
      if (a == 5'h14) return {30'b0, m_busy, m_done};
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_data   = '0;
      m_op     = '0;
      m_result = '0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_left   = 0;
   endtask

   // Advances the model by one clock edge given the inputs sampled at it.
   task automatic model_step(input bit c, input bit w,
                             input logic [4:0] a, input logic [15:0] d);
      bit was_busy;
      was_busy = m_busy;
      if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy   = 1'b0;
            m_done   = 1'b1;
            m_result = ref_conv(m_op);
         end
      end
      if (c && w) begin
         if (a == 5'h08 && d[0] && !was_busy) begin
            m_op   = m_data;
            m_busy = 1'b1;
            m_done = 1'b0;
            m_left = 16;
         end
         if (a == 5'h04) m_data = d;
      end
   endtask

   task automatic cyc(input bit c, input bit w, input bit r,
                      input logic [4:0] a, input logic [15:0] d,
                      input bit ovr, input logic [31:0] ov);
      rd_t e;
      @(negedge clk);
      bus.cs   = c;
      bus.wr   = w;
      bus.rd   = r;
      bus.addr = a;
      bus.d_in = d;
      if (c && r) begin
         e.addr = a;
         e.exp  = ovr ? ov : model_rd(a);
         sb_q.push_back(e);
      end
      @(posedge clk);
      model_step(c, w, a, d);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 5'h0, 16'h0, 0, 0);
   endtask
   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      cyc(1, 1, 0, a, d, 0, 0);
   endtask
   task automatic rd(input logic [4:0] a);
      cyc(1, 0, 1, a, 16'h0, 0, 0);
   endtask
   task automatic rd_const(input logic [4:0] a, input logic [31:0] v);
      cyc(1, 0, 1, a, 16'h0, 1, v);
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic convert(input logic [15:0] v, input logic [31:0] exp);
      wr(5'h04, v);
      wr(5'h08, 16'h1);
      repeat (18) rd(5'h14);
      rd_const(5'h10, exp);
   endtask

   task automatic async_reset();
      @(negedge clk);
      bus.cs = 0;
      bus.wr = 0;
      bus.rd = 0;
      #1 reset = 1'b0;
      #1;
      check("rst_dout", bus.d_out, 32'h0);
      check("rst_busy", {31'b0, dut.r_busy}, 32'h0);
      check("rst_done", {31'b0, dut.r_done}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      model_reset();
   endtask

   initial begin : mon
      rd_t e;
      forever begin
         @(posedge clk);
         if (reset && bus.cs && bus.rd) begin
            #1;
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL rd_underflow: got %h expected none", bus.d_out);
            end else begin
               e = sb_q.pop_front();
               if (bus.d_out !== e.exp) begin
                  n_fail++;
                  $display("FAIL rd@%h: got %h expected %h",
                           e.addr, bus.d_out, e.exp);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   logic [15:0] edges [5] = '{16'h0000, 16'hFFFF, 16'h0007,
                              16'h8000, 16'h7FFF};

   initial begin
      bus.cs   = 0;
      bus.wr   = 0;
      bus.rd   = 0;
      bus.addr = '0;
      bus.d_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check("init_dout", bus.d_out, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);

      rd_const(5'h14, 32'h0);
      rd_const(5'h10, 32'h0);
      rd_const(5'h04, 32'h0);

      convert(16'd7, 32'h0000_0007);
`ifdef PERIPHERAL_BIN2BCD_SIGNED_EN
      convert(16'hFB2E, 32'h0010_1234);
      convert(16'h8000, 32'h0013_2768);
`else
      convert(16'hFFFF, 32'h0006_5535);
`endif
      convert(16'd0, 32'h0000_0000);
      rd_const(5'h14, 32'h1);

      // Start ignored while busy; the newer DATA feeds the next run.
      wr(5'h04, 16'd1234);
      wr(5'h08, 16'h1);
      repeat (4) rd(5'h14);
      wr(5'h04, 16'd9999);
      wr(5'h08, 16'h1);
      repeat (14) rd(5'h14);
      rd_const(5'h10, 32'h0000_1234);
      wr(5'h08, 16'h1);
      repeat (18) rd(5'h14);
      rd_const(5'h10, 32'h0000_9999);

      cyc(1, 1, 1, 5'h10, 16'h5A5A, 1, 32'h0000_9999);
      rd_const(5'h10, 32'h0000_9999);
      rd_const(5'h14, 32'h1);
      rd_const(5'h18, 32'h0);

      wr(5'h04, 16'd1234);
      wr(5'h08, 16'h1);
      repeat (8) rd(5'h14);
      async_reset();
      rd_const(5'h14, 32'h0);
      rd_const(5'h10, 32'h0);
      convert(16'd42, 32'h0000_0042);

      for (int n = 0; n < 30; n++) begin
         logic [15:0] v;
         v = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)]
                                         : 16'($urandom);
         wr(5'h04, v);
         wr(5'h08, 16'h1);
         for (int k = 0; k < 12 + int'($urandom_range(0, 10)); k++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: rd(5'h14);
               5: wr(5'h04, 16'($urandom));
               6: wr(5'h08, 16'($urandom));
               7: rd(5'($urandom_range(0, 31)));
               8: cyc(1, 1, 1, 5'($urandom_range(0, 31)),
                      16'($urandom), 0, 0);
               default: idle();
            endcase
         end
         repeat (18) rd(5'h14);
         rd(5'h10);
      end

      idle();
      idle();
      repeat (3) @(posedge clk);
      check("sb_drain", sb_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
